// File: rtl/audio_frame_packer.sv
// Packs strobed 16-bit audio samples into a two-bank ping-pong buffer and serves each full bank
// to the UDP transmit core as one frame: a header word {SYNC_WORD, seq} followed by packed pairs.
module audio_frame_packer #(
  parameter int unsigned FRAME_SAMPLES = 256,
  parameter logic [15:0] SYNC_WORD     = 16'hAA55
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [15:0] audio_data,
  input  logic        audio_en,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  input  logic        tx_req,
  output logic [31:0] tx_data,
  input  logic        tx_done,
  output logic        overflow,
  output logic [15:0] drop_cnt
);

  localparam int unsigned Words = FRAME_SAMPLES / 2;
  localparam int unsigned IdxW  = $clog2(FRAME_SAMPLES);
  localparam int unsigned RdW   = $clog2(Words + 1);

  typedef enum logic [1:0] {StIdle, StStart, StSend, StWaitDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [IdxW-1:0]   wr_idx_q, wr_idx_d;
  logic [RdW-1:0]    rd_idx_q, rd_idx_d;
  logic [15:0]       pending_q, pending_d;
  logic [15:0]       seq_q, seq_d;
  logic [31:0]       tx_data_q, tx_data_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  // Bank b occupies addresses {b, word}; unused slots exist when Words is not a power of two.
  logic [31:0]       mem_q [2**IdxW];
  logic              mem_we;
  logic [IdxW-1:0]   mem_waddr;
  logic [31:0]       mem_wdata;
  logic [IdxW-2:0]   rd_word;
  logic [IdxW-1:0]   mem_raddr;

  assign tx_byte_num = 16'(4 + 2 * FRAME_SAMPLES);
  assign tx_start_en = (state_q == StStart);
  assign tx_data     = tx_data_q;
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_cnt_q;

  assign rd_word   = rd_idx_q[IdxW-2:0] - (IdxW-1)'(1);
  assign mem_raddr = {rd_bank_q, rd_word};
  assign mem_waddr = {wr_bank_q, wr_idx_q[IdxW-1:1]};
  assign mem_wdata = {pending_q, audio_data};

  always_comb begin
    state_d     = state_q;
    bank_full_d = bank_full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    pending_d   = pending_q;
    seq_d       = seq_q;
    tx_data_d   = tx_data_q;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;
    mem_we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tx_req) tx_data_d = '0;
        if (bank_full_q[rd_bank_q]) state_d = StStart;
      end
      StStart: begin
        if (tx_req) tx_data_d = '0;
        rd_idx_d = '0;
        state_d  = StSend;
      end
      StSend: begin
        if (tx_req) begin
          tx_data_d = (rd_idx_q == '0) ? {SYNC_WORD, seq_q} : mem_q[mem_raddr];
          if (rd_idx_q == RdW'(Words)) state_d = StWaitDone;
          else rd_idx_d = rd_idx_q + RdW'(1);
        end
      end
      StWaitDone: begin
        if (tx_req) tx_data_d = '0;
        if (tx_done) begin
          bank_full_d[rd_bank_q] = 1'b0;
          rd_bank_d = ~rd_bank_q;
          seq_d     = seq_q + 16'd1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Write side sees the post-release flags so a coincident release frees the bank first.
    if (audio_en) begin
      if (bank_full_d[wr_bank_q]) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end else begin
        if (!wr_idx_q[0]) pending_d = audio_data;
        else mem_we = 1'b1;
        if (wr_idx_q == IdxW'(FRAME_SAMPLES - 1)) begin
          bank_full_d[wr_bank_q] = 1'b1;
          wr_bank_d = ~wr_bank_q;
          wr_idx_d  = '0;
        end else begin
          wr_idx_d = wr_idx_q + IdxW'(1);
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      bank_full_q <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      pending_q   <= '0;
      seq_q       <= '0;
      tx_data_q   <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      pending_q   <= pending_d;
      seq_q       <= seq_d;
      tx_data_q   <= tx_data_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_audio_frame_packer.sv
// Directed bench for audio_frame_packer with FRAME_SAMPLES=4: cycle table plus reset-mid-frame.
module tb_audio_frame_packer;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [15:0] audio_data;
  logic        audio_en;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic        tx_req;
  logic [31:0] tx_data;
  logic        tx_done;
  logic        overflow;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  audio_frame_packer #(
    .FRAME_SAMPLES(4),
    .SYNC_WORD    (16'hAA55)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .audio_data (audio_data),
    .audio_en   (audio_en),
    .tx_start_en(tx_start_en),
    .tx_byte_num(tx_byte_num),
    .tx_req     (tx_req),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int          gap;
    logic        en;
    logic [15:0] d;
    logic        req;
    logic        done;
    logic        start;
    logic [31:0] data;
    logic        ovf;
    logic [15:0] drop;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int gap, input logic en, input logic [15:0] d, input logic req,
                     input logic done, input logic start, input logic [31:0] data,
                     input logic ovf, input logic [15:0] drop);
    vec_t v;
    v.gap = gap; v.en = en; v.d = d; v.req = req; v.done = done;
    v.start = start; v.data = data; v.ovf = ovf; v.drop = drop;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive for one rising edge, return at the following negedge.
  task automatic cycle(input logic en, input logic [15:0] d, input logic req, input logic done);
    audio_en = en; audio_data = d; tx_req = req; tx_done = done;
    @(posedge sys_clk);
    @(negedge sys_clk);
    audio_en = 1'b0; audio_data = '0; tx_req = 1'b0; tx_done = 1'b0;
  endtask

  initial begin
    int n;
    bit seen;
    // gap, en, data, req, done | start, tx_data, overflow, drop_cnt (after the edge)
    add(9, 1, 16'h0001, 0, 0, 0, 32'h0, 0, 0);
    add(9, 1, 16'h0002, 0, 0, 0, 32'h0, 0, 0);
    add(9, 1, 16'h0003, 0, 0, 0, 32'h0, 0, 0);
    add(9, 1, 16'h0004, 0, 0, 0, 32'h0, 0, 0);
    add(0, 0, 16'h0000, 0, 0, 1, 32'h0, 0, 0);
    add(0, 0, 16'h0000, 0, 0, 0, 32'h0, 0, 0);
    add(0, 0, 16'h0000, 1, 0, 0, 32'hAA550000, 0, 0);
    add(0, 0, 16'h0000, 1, 0, 0, 32'h00010002, 0, 0);
    add(0, 0, 16'h0000, 1, 0, 0, 32'h00030004, 0, 0);
    add(9, 1, 16'h0005, 0, 0, 0, 32'h00030004, 0, 0);
    add(9, 1, 16'h0006, 0, 0, 0, 32'h00030004, 0, 0);
    add(9, 1, 16'h0007, 0, 0, 0, 32'h00030004, 0, 0);
    add(9, 1, 16'h0008, 0, 0, 0, 32'h00030004, 0, 0);
    add(0, 0, 16'h0000, 0, 1, 0, 32'h00030004, 0, 0);
    add(0, 0, 16'h0000, 0, 0, 1, 32'h00030004, 0, 0);
    add(0, 0, 16'h0000, 0, 0, 0, 32'h00030004, 0, 0);
    add(0, 0, 16'h0000, 1, 0, 0, 32'hAA550001, 0, 0);
    add(0, 0, 16'h0000, 1, 0, 0, 32'h00050006, 0, 0);
    add(0, 0, 16'h0000, 1, 0, 0, 32'h00070008, 0, 0);
    // tx_done withheld: bank 0 refills, the next sample is dropped
    add(0, 1, 16'h0009, 0, 0, 0, 32'h00070008, 0, 0);
    add(0, 1, 16'h000A, 0, 0, 0, 32'h00070008, 0, 0);
    add(0, 1, 16'h000B, 0, 0, 0, 32'h00070008, 0, 0);
    add(0, 1, 16'h000C, 0, 0, 0, 32'h00070008, 0, 0);
    add(0, 1, 16'h000D, 0, 0, 0, 32'h00070008, 1, 1);
    // sample coincident with release lands in the freed bank
    add(0, 1, 16'h000E, 0, 1, 0, 32'h00070008, 1, 1);
    add(0, 0, 16'h0000, 0, 0, 1, 32'h00070008, 1, 1);
    add(0, 0, 16'h0000, 0, 0, 0, 32'h00070008, 1, 1);
    add(0, 0, 16'h0000, 1, 0, 0, 32'hAA550002, 1, 1);
    add(0, 0, 16'h0000, 1, 0, 0, 32'h0009000A, 1, 1);
    add(0, 0, 16'h0000, 1, 0, 0, 32'h000B000C, 1, 1);
    add(0, 0, 16'h0000, 1, 0, 0, 32'h00000000, 1, 1);
    add(0, 0, 16'h0000, 0, 1, 0, 32'h00000000, 1, 1);
    add(0, 1, 16'h000F, 0, 0, 0, 32'h00000000, 1, 1);
    add(0, 1, 16'h0010, 0, 0, 0, 32'h00000000, 1, 1);
    add(0, 1, 16'h0011, 0, 0, 0, 32'h00000000, 1, 1);
    add(0, 0, 16'h0000, 0, 0, 1, 32'h00000000, 1, 1);
    add(0, 0, 16'h0000, 0, 0, 0, 32'h00000000, 1, 1);
    add(0, 0, 16'h0000, 1, 0, 0, 32'hAA550003, 1, 1);
    add(0, 0, 16'h0000, 1, 0, 0, 32'h000E000F, 1, 1);
    add(0, 0, 16'h0000, 1, 0, 0, 32'h00100011, 1, 1);
    add(0, 0, 16'h0000, 0, 1, 0, 32'h00100011, 1, 1);

    sys_rst = 1'b1; audio_en = 1'b0; audio_data = '0; tx_req = 1'b0; tx_done = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("reset tx_start_en", 32'(tx_start_en), 32'd0);
    chk("reset tx_data", tx_data, 32'h0);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset drop_cnt", 32'(drop_cnt), 32'd0);
    chk("tx_byte_num", 32'(tx_byte_num), 32'd12);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    for (int i = 0; i < vecs.size(); i++) begin
      repeat (vecs[i].gap) cycle(1'b0, 16'h0, 1'b0, 1'b0);
      cycle(vecs[i].en, vecs[i].d, vecs[i].req, vecs[i].done);
      chk($sformatf("v%0d tx_start_en", i), 32'(tx_start_en), 32'(vecs[i].start));
      chk($sformatf("v%0d tx_data", i), tx_data, vecs[i].data);
      chk($sformatf("v%0d overflow", i), 32'(overflow), 32'(vecs[i].ovf));
      chk($sformatf("v%0d drop_cnt", i), 32'(drop_cnt), 32'(vecs[i].drop));
    end

    // Reset after two of three words of frame seq=4
    for (int s = 0; s < 4; s++) cycle(1'b1, 16'(16'h21 + s), 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    chk("pre-reset header", tx_data, 32'hAA550004);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    chk("pre-reset word0", tx_data, 32'h00210022);
    sys_rst = 1'b1;
    #1;
    chk("mid-reset tx_start_en", 32'(tx_start_en), 32'd0);
    chk("mid-reset tx_data", tx_data, 32'h0);
    chk("mid-reset overflow", 32'(overflow), 32'd0);
    chk("mid-reset drop_cnt", 32'(drop_cnt), 32'd0);
    chk("mid-reset tx_byte_num", 32'(tx_byte_num), 32'd12);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    cycle(1'b1, 16'h0031, 1'b0, 1'b0);
    cycle(1'b1, 16'h0032, 1'b0, 1'b0);
    chk("post-reset no start", 32'(tx_start_en), 32'd0);
    cycle(1'b1, 16'h0033, 1'b0, 1'b0);
    cycle(1'b1, 16'h0034, 1'b0, 1'b0);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 10) begin
      cycle(1'b0, 16'h0, 1'b0, 1'b0);
      seen = tx_start_en;
      n++;
    end
    chk("post-reset start seen", 32'(seen), 32'd1);
    chk("post-reset start latency", n, 1);
    cycle(1'b0, 16'h0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    chk("post-reset header", tx_data, 32'hAA550000);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    chk("post-reset word0", tx_data, 32'h00310032);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    chk("post-reset word1", tx_data, 32'h00330034);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    chk("post-reset excess", tx_data, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_frame_packer.md
Name: audio_frame_packer

Overview:
- Sits between the voice-loop ADC sample output and the UDP transmit core.
- Collects 16-bit audio samples qualified by a valid strobe into a ping-pong buffer of two banks.
- When a bank fills, it requests one UDP frame and serves payload words to the UDP core on its read handshake. Each frame is one header word followed by the packed samples.
- Runs entirely in the UDP transmit clock domain. Samples arrive already synchronised, one-cycle audio_en pulses.

Parameters:
- FRAME_SAMPLES, 256, samples per frame/bank. Must be even, 4..1024.
- SYNC_WORD, 16'hAA55, upper half of the header word.

Ports:
- sys_clk  in  1  clock (UDP tx clock).
- sys_rst  in  1  asynchronous reset, active-high.
- audio_data  in  16  signed PCM sample.
- audio_en  in  1  one-cycle sample strobe.
- tx_start_en  out  1  one-cycle frame request to the UDP core.
- tx_byte_num  out  16  payload byte count, constant 4 + 2*FRAME_SAMPLES.
- tx_req  in  1  UDP core requests the next 32-bit payload word.
- tx_data  out  32  payload word.
- tx_done  in  1  one-cycle pulse: UDP frame fully sent.
- overflow  out  1  sticky: at least one sample dropped.
- drop_cnt  out  16  dropped-sample count, saturates at 16'hFFFF.

Behaviour:
- Reset values:
  - tx_start_en=0, tx_data=0, overflow=0, drop_cnt=0.
  - Both bank_full flags=0, wr_bank=0, rd_bank=0, seq=0, FSM=IDLE.
  - Pending-half register cleared.
  - tx_byte_num is constant, not reset-dependent.
- Storage: 2 banks of FRAME_SAMPLES/2 words, 32 bits each.
- Packing: word k = {sample 2k, sample 2k+1}, the earlier sample in [31:16].
  - An even-index sample is held in the pending register.
  - The odd-index sample writes the word.
- Write side:
  - On audio_en with bank_full[wr_bank]=0: store the sample and advance the sample index.
  - On the edge capturing sample FRAME_SAMPLES-1: set bank_full[wr_bank], toggle wr_bank, reset the index to 0.
  - audio_en while bank_full[wr_bank]=1: sample dropped, overflow<=1, drop_cnt+1 (saturating), index unchanged.
- Read FSM: IDLE -> START -> SEND -> WAIT_DONE -> IDLE.
  - IDLE: if bank_full[rd_bank], go to START.
  - START:
    - tx_start_en=1 for exactly this one cycle.
    - Read index=0.
    - Go to SEND.
    - Timing: last sample captured at edge T gives tx_start_en high from edge T+1 to T+2.
  - SEND: on each tx_req edge, tx_data is registered and valid the cycle after tx_req.
    - Read 0 gives {SYNC_WORD, seq}.
    - Reads 1..FRAME_SAMPLES/2 give bank words 0..FRAME_SAMPLES/2-1.
    - After the last word is served, go to WAIT_DONE.
  - Excess tx_req, in WAIT_DONE or IDLE: tx_data<=0, no pointer change.
  - WAIT_DONE: on tx_done, clear bank_full[rd_bank], toggle rd_bank, seq+1 (wraps at 16 bits), go to IDLE.
  - tx_done in any other state is ignored.
- Simultaneous events:
  - A bank release (tx_done) and audio_en in the same cycle: the release takes effect first. A sample targeting the just-released bank is accepted, not dropped.
  - Bank fill and release in the same cycle act on different banks; both take effect.
- Reset mid-frame: all state returns to reset values immediately and any partially filled or partially sent frame is discarded. The UDP core is reset independently.
- Throughput: one tx_req per cycle is sustainable; no wait states.

Test Plan:
- FRAME_SAMPLES=4; samples 0x0001..0x0004 at 1 per 10 cycles.
  - tx_start_en pulses once, 1 cycle after the 4th capture edge; tx_byte_num=12.
  - tx_req x3 gives 0xAA550000, 0x00010002, 0x00030004.
- Continue with samples 0x0005..0x0008, then tx_done for frame 0.
  - Second frame header 0xAA550001, data 0x00050006, 0x00070008.
- Withhold tx_done and send 9 samples after the first full bank.
  - The second bank fills and the 9th sample is dropped: overflow=1, drop_cnt=1.
  - After tx_done the second frame starts and its data is intact.
- audio_en coincident with tx_done while both banks are full: the sample is stored in the released bank; drop_cnt is unchanged.
- 4 tx_req pulses for a 3-word frame: the 4th returns 0x00000000; no pointer corruption on the next frame.
- Assert sys_rst after 2 of 3 words are sent: all outputs return to reset values. The next frame carries header seq=0 and fresh samples only.
